// File: rtl/ram_sp_clr_if.sv
// Request/read/clear bundle between a client (master) and ram_sp_clr (slave).
// Read results return on rd_valid/rd_data; clr_start/busy/clr_done drive the clear engine.
interface ram_sp_clr_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
);
  localparam int BE_W = DATA_W / 8;

  logic              req_valid;
  logic              req_ready;
  logic              req_wr;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [BE_W-1:0]   req_be;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              clr_start;
  logic              busy;
  logic              clr_done;

  modport master (
    output req_valid, req_wr, req_addr, req_wdata, req_be, clr_start,
    input  req_ready, rd_valid, rd_data, busy, clr_done
  );

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata, req_be, clr_start,
    output req_ready, rd_valid, rd_data, busy, clr_done
  );
endinterface

// File: rtl/ram_sp_clr.sv
// Single-port RAM with byte enables and a one-word-per-cycle clear engine (DEPTH cycles after reset / clr_start).
// Read latency 1, or 2 with RAM_OUT_REG_EN defined (clr_done delayed by the same extra cycle).
// req_ready is low for the whole clear; requests wait, clr_start is ignored while clearing.
module ram_sp_clr #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int BE_W   = DATA_W / 8
) (
  input  logic        clk,
  input  logic        rst_n,
  ram_sp_clr_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    ST_CLR  = 1'b0,
    ST_IDLE = 1'b1
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] clr_addr_q;
  logic [ADDR_W-1:0] clr_addr_d;
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q;
  logic              clr_done_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [BE_W-1:0]   wr_be;

  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.busy      = (state_q == ST_CLR);
  assign accept        = bus.req_valid && (state_q == ST_IDLE);
  assign clr_addr_d    = clr_addr_q + 1'b1;

  // The clear engine and client writes share the single write port.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = clr_addr_q;
    wr_data = '0;
    wr_be   = '1;
    if (state_q == ST_CLR) begin
      wr_en = 1'b1;
    end else if (accept && bus.req_wr) begin
      wr_en   = 1'b1;
      wr_addr = bus.req_addr;
      wr_data = bus.req_wdata;
      wr_be   = bus.req_be;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < BE_W; i++) begin
        if (wr_be[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_CLR;
      clr_addr_q <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      clr_done_q <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      clr_done_q <= 1'b0;
      case (state_q)
        ST_CLR: begin
          clr_addr_q <= clr_addr_d;
          if (clr_addr_q == ADDR_W'(DEPTH - 1)) begin
            state_q    <= ST_IDLE;
            clr_done_q <= 1'b1;
          end
        end
        default: begin
          if (accept && !bus.req_wr) begin
            rd_data_q  <= mem[bus.req_addr];
            rd_valid_q <= 1'b1;
          end
          if (bus.clr_start) state_q <= ST_CLR;
        end
      endcase
    end
  end

`ifdef RAM_OUT_REG_EN
  logic [DATA_W-1:0] rd_data_o_q;
  logic              rd_valid_o_q;
  logic              clr_done_o_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_o_q  <= '0;
      rd_valid_o_q <= 1'b0;
      clr_done_o_q <= 1'b0;
    end else begin
      rd_data_o_q  <= rd_data_q;
      rd_valid_o_q <= rd_valid_q;
      clr_done_o_q <= clr_done_q;
    end
  end

  assign bus.rd_data  = rd_data_o_q;
  assign bus.rd_valid = rd_valid_o_q;
  assign bus.clr_done = clr_done_o_q;
`else
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.clr_done = clr_done_q;
`endif
endmodule

// File: tb/tb_ram_sp_clr.sv
// Bench for ram_sp_clr: reference memory model plus a queue of expected read results with due cycles.
module tb_ram_sp_clr;
  localparam int DW = 16;
  localparam int AW = 4;
`ifdef RAM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  exp_t sb[$];
  logic [DW-1:0] model [16];

  ram_sp_clr_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  ram_sp_clr #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Advance one cycle, sample at the falling edge and retire any read result.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (rst_n && bus.rd_valid) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL rd_valid_unexpected cyc=%0d got rd_valid=1 rd_data=%h want rd_valid=0", cyc, bus.rd_data);
      end else begin
        e = sb.pop_front();
        if (bus.rd_data !== e.data || cyc != e.due) begin
          bad++;
          $display("FAIL read_result got data=%h cyc=%0d want data=%h cyc=%0d", bus.rd_data, cyc, e.data, e.due);
        end
      end
    end
    if (sb.size() > 0 && sb[0].due < cyc) begin
      total++;
      bad++;
      e = sb.pop_front();
      $display("FAIL read_missing cyc=%0d got no rd_valid want data=%h at cyc=%0d", cyc, e.data, e.due);
    end
  endtask

  task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] be);
    int w = 0;
    while (!bus.req_ready && w < 64) begin
      tick();
      w++;
    end
    if (!bus.req_ready) begin
      total++;
      bad++;
      $display("FAIL issue_timeout got req_ready=0 want req_ready=1");
    end
    bus.req_valid = 1'b1;
    bus.req_wr    = wr;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.req_be    = be;
    if (wr) begin
      for (int i = 0; i < 2; i++) if (be[i]) model[a][8*i +: 8] = d[8*i +: 8];
    end else begin
      sb.push_back('{data: model[a], due: cyc + LAT});
    end
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 8 && sb.size() > 0; k++) tick();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain got pending=%0d want pending=0", sb.size());
      sb.delete();
    end
  endtask

  // Tick through a clear from the current sample, dropping req_valid as soon as busy falls.
  task automatic measure_clear(output int nbusy, output int done_cnt, output int done_off);
    nbusy = 0;
    done_cnt = 0;
    done_off = -1;
    for (int k = 0; k < 40 && bus.busy; k++) begin
      nbusy++;
      if (bus.clr_done) done_cnt++;
      tick();
    end
    bus.req_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (bus.clr_done) begin
        done_cnt++;
        if (done_off < 0) done_off = k;
      end
      tick();
    end
    for (int i = 0; i < 16; i++) model[i] = '0;
  endtask

  task automatic test_reset();
    int nb, dc, doff;
    tick();
    tick();
    total++;
    if (bus.busy !== 1'b1 || bus.req_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_busy_ready got busy=%b ready=%b want busy=1 ready=0", bus.busy, bus.req_ready);
    end
    total++;
    if (bus.rd_valid !== 1'b0 || bus.rd_data !== 16'h0000 || bus.clr_done !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs got rd_valid=%b rd_data=%h clr_done=%b want 0/0000/0",
               bus.rd_valid, bus.rd_data, bus.clr_done);
    end
    rst_n = 1'b1;
    measure_clear(nb, dc, doff);
    total++;
    if (nb != 16) begin
      bad++;
      $display("FAIL reset_clear_len got busy_cycles=%0d want 16", nb);
    end
    total++;
    if (dc != 1 || doff != LAT - 1) begin
      bad++;
      $display("FAIL reset_clr_done got pulses=%0d offset=%0d want pulses=1 offset=%0d", dc, doff, LAT - 1);
    end
    for (int a = 0; a < 16; a++) issue(1'b0, AW'(a), '0, 2'b00);
    drain();
  endtask

  task automatic test_byte_enable();
    issue(1'b1, 4'd5, 16'hA5C3, 2'b11);
    issue(1'b1, 4'd5, 16'hFF00, 2'b01);
    issue(1'b1, 4'd6, 16'hBEEF, 2'b00);
    issue(1'b0, 4'd5, '0, 2'b00);
    issue(1'b0, 4'd5, '0, 2'b00);
    issue(1'b0, 4'd6, '0, 2'b00);
    drain();
    tick();
    total++;
    if (bus.rd_valid !== 1'b0 || bus.rd_data !== 16'h0000) begin
      bad++;
      $display("FAIL be_hold got rd_valid=%b rd_data=%h want 0/0000", bus.rd_valid, bus.rd_data);
    end
  endtask

  task automatic test_back_to_back();
    issue(1'b1, 4'd1, 16'h1111, 2'b11);
    issue(1'b1, 4'd2, 16'h2222, 2'b11);
    issue(1'b1, 4'd3, 16'h3333, 2'b11);
    issue(1'b0, 4'd1, '0, 2'b00);
    issue(1'b0, 4'd2, '0, 2'b00);
    issue(1'b0, 4'd3, '0, 2'b00);
    drain();
    tick();
    total++;
    if (bus.rd_valid !== 1'b0 || bus.rd_data !== 16'h3333) begin
      bad++;
      $display("FAIL b2b_hold got rd_valid=%b rd_data=%h want 0/3333", bus.rd_valid, bus.rd_data);
    end
  endtask

  task automatic test_clear_with_read();
    int nb, dc, doff;
    issue(1'b1, 4'd7, 16'h7777, 2'b11);
    bus.req_valid = 1'b1;
    bus.req_wr    = 1'b0;
    bus.req_addr  = 4'd7;
    bus.clr_start = 1'b1;
    sb.push_back('{data: model[7], due: cyc + LAT});
    tick();
    bus.clr_start = 1'b0;
    bus.req_addr  = 4'd3;
    measure_clear(nb, dc, doff);
    total++;
    if (nb != 16) begin
      bad++;
      $display("FAIL clr_req_len got busy_cycles=%0d want 16", nb);
    end
    total++;
    if (dc != 1 || doff != LAT - 1) begin
      bad++;
      $display("FAIL clr_req_done got pulses=%0d offset=%0d want pulses=1 offset=%0d", dc, doff, LAT - 1);
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL clr_req_read got pending=%0d want 0", sb.size());
      sb.delete();
    end
    issue(1'b0, 4'd7, '0, 2'b00);
    issue(1'b0, 4'd3, '0, 2'b00);
    drain();
  endtask

  task automatic test_reset_mid_clear();
    int nb, dc, doff;
    issue(1'b1, 4'd9, 16'h9999, 2'b11);
    bus.req_valid = 1'b1;
    bus.req_wr    = 1'b0;
    bus.req_addr  = 4'd9;
    bus.clr_start = 1'b1;
    sb.push_back('{data: model[9], due: cyc + LAT});
    tick();
    bus.clr_start = 1'b0;
    bus.req_valid = 1'b0;
    for (int k = 0; k < 7; k++) tick();
    total++;
    if (bus.busy !== 1'b1 || bus.rd_data !== 16'h9999) begin
      bad++;
      $display("FAIL midclr_pre got busy=%b rd_data=%h want 1/9999", bus.busy, bus.rd_data);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.rd_valid !== 1'b0 || bus.rd_data !== 16'h0000 || bus.clr_done !== 1'b0) begin
      bad++;
      $display("FAIL midclr_reset got rd_valid=%b rd_data=%h clr_done=%b want 0/0000/0",
               bus.rd_valid, bus.rd_data, bus.clr_done);
    end
    sb.delete();
    tick();
    tick();
    rst_n = 1'b1;
    measure_clear(nb, dc, doff);
    total++;
    if (nb != 16) begin
      bad++;
      $display("FAIL midclr_len got busy_cycles=%0d want 16", nb);
    end
    issue(1'b0, 4'd9, '0, 2'b00);
    drain();
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_wr    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_be    = '0;
    bus.clr_start = 1'b0;
    for (int i = 0; i < 16; i++) model[i] = '0;
    test_reset();
    test_byte_enable();
    test_back_to_back();
    test_clear_with_read();
    test_reset_mid_clear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ram_sp_clr.md
Name: ram_sp_clr

Overview:
Parametrised single-port synchronous RAM and the successor to the team's fixed 16x16 RAM. It adds the following:
- configurable width and depth
- per-byte write enables
- a valid/ready request handshake
- a registered read-valid strobe
- a hardware clear engine that zeroes memory one word per cycle, both after reset and on request

It serves as generic scratch/buffer storage behind controller FSMs, replacing reset-time bulk clearing of the array.

Parameters:
DATA_W, 16, data word width in bits; must be a multiple of 8.
ADDR_W, 4, address width; DEPTH = 2**ADDR_W words.
BE_W, DATA_W/8, number of byte-enable bits (derived; do not override).

Ports:
clk  input  1  clock, all logic on rising edge.
rst_n  input  1  asynchronous active-low reset.
req_valid  input  1  request present.
req_ready  output  1  block can accept a request this cycle.
req_wr  input  1  1 = write, 0 = read.
req_addr  input  ADDR_W  word address.
req_wdata  input  DATA_W  write data.
req_be  input  BE_W  byte enables; bit i covers req_wdata[8i+7:8i].
rd_valid  output  1  rd_data holds a fresh read result (one-cycle pulse).
rd_data  output  DATA_W  read data; holds its last value between reads.
clr_start  input  1  request full-memory clear.
busy  output  1  clear engine active.
clr_done  output  1  one-cycle pulse when a clear completes.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: rd_data=0, rd_valid=0, clr_done=0. State=CLR with clear address 0, so busy=1 and req_ready=0 from reset.
- The memory array itself is not reset; it is zeroed by the clear engine.
- States: CLR and IDLE. busy = (state==CLR). req_ready = (state==IDLE), combinational from state only.
- CLR state:
  - Each cycle, write 0 to the word at the clear address, then increment the clear address.
  - After writing address DEPTH-1, go to IDLE and reset the clear address to 0.
  - A full clear occupies exactly DEPTH cycles. clr_done pulses high for the first IDLE cycle.
  - clr_start is ignored in CLR.
  - req_valid is ignored in CLR; nothing is accepted because req_ready=0.
- IDLE state:
  - A request is accepted when req_valid && req_ready.
  - Write accepted at edge N: every byte with req_be[i]=1 is updated at edge N; other bytes are unchanged. req_be=0 is accepted as a no-op. rd_valid is not asserted for writes.
  - Read accepted at edge N: rd_data = mem[req_addr] and rd_valid=1 after edge N, i.e. latency 1.
  - rd_valid drops after one cycle unless another read is accepted. Back-to-back reads give rd_valid=1 on consecutive cycles.
  - Read the cycle after a write to the same address: returns the newly written data (no bypass needed).
- clr_start in IDLE:
  - State becomes CLR at the next edge.
  - If a request is also accepted that same cycle, it completes normally at that edge, including its rd_valid pulse. The clear starts afterwards.
- Reset mid-clear or mid-read: outputs return to reset values immediately and the clear restarts from address 0 after rst_n deasserts. A pending rd_valid is lost.
- Addresses cover DEPTH exactly, so no out-of-range case exists. The clear address wraps naturally at DEPTH-1 -> 0.

Optional Feature:
RAM_OUT_REG_EN
- Defined:
  - An extra output register stage is inserted, making read latency 2. rd_data and rd_valid both move one cycle later.
  - rd_data still holds between reads and resets to 0.
  - clr_done also gains one extra cycle of delay, so it stays aligned after the last rd_valid of a request issued with clr_start.
- Undefined: read latency 1 as above.

Test Plan:
- Release rst_n with defaults -> busy=1 and req_ready=0 for exactly 16 cycles; clr_done pulses once; then reads of addresses 0..15 all return 0x0000 with rd_valid one cycle after acceptance.
- Write addr 5 data 0xA5C3 be=2'b11, then write addr 5 data 0xFF00 be=2'b01, then read addr 5 -> rd_data=0xA500; next-cycle read returns the same.
- Back-to-back reads of addr 1, 2, 3 (preloaded 0x1111, 0x2222, 0x3333) -> rd_valid high three consecutive cycles with the data in order; rd_data holds 0x3333 afterwards with rd_valid=0.
- Read addr 7 (0x7777) in the same cycle as clr_start -> rd_data=0x7777 with rd_valid next cycle, then busy for 16 cycles with req_valid held high and no acceptance; read addr 7 afterwards -> 0x0000.
- Assert rst_n=0 at clear cycle 8 -> rd_valid=0 and rd_data=0 immediately; after release busy lasts a full 16 cycles.
- With RAM_OUT_REG_EN defined: repeat the back-to-back read test -> identical data sequence delayed by one extra cycle.
